// File: rtl/fazyrv_rf_port_pkg.sv
// Shared types and sizing helpers for the word-level RF access port.
// Holds the FSM state enum and chunk-count helpers.
package fazyrv_rf_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    function automatic int nchunk(input int cs);
        return 32 / cs;
    endfunction

    function automatic int cntw(input int cs);
        return ((32 / cs) > 2) ? $clog2(32 / cs) : 1;
    endfunction

endpackage

// File: rtl/fazyrv_rf_port_sreg.sv
// Combined write/capture chunk shifter: write word leaves LSB chunk first,
// captured chunks enter at the MSB so a full rotation rebuilds the word.
// Ports: clk_i, rst_in (sync, active-low), load_i, wdat_i, shift_i,
//        in_i (chunk in), out_o (chunk out), cap_o (captured word).
module fazyrv_rf_port_sreg #(
    parameter int CHUNKSIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 load_i,
    input  logic [31:0]          wdat_i,
    input  logic                 shift_i,
    input  logic [CHUNKSIZE-1:0] in_i,
    output logic [CHUNKSIZE-1:0] out_o,
    output logic [31:0]          cap_o
);

    logic [31:0] r_wsr;
    logic [31:0] r_cap;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_wsr <= '0;
            r_cap <= '0;
        end else if (load_i) begin
            r_wsr <= wdat_i;
            r_cap <= '0;
        end else if (shift_i) begin
            r_wsr <= r_wsr >> CHUNKSIZE;
            r_cap <= {in_i, r_cap[31:CHUNKSIZE]};
        end
    end

    assign out_o = r_wsr[CHUNKSIZE-1:0];
    assign cap_o = r_cap;

endmodule

// File: rtl/fazyrv_rf_port.sv
// Word-level read/write port onto the chunk-serial register file.
// Each access rotates x[addr] once: NCHUNK shift cycles, then a DONE pulse.
// Ports: clk_i, rst_in (sync, active-low), gnt_i, req_i/wr_i/addr_i/wdat_i
//        request side, ready_o/rdat_o completion, rf_* to/from the RF.
// Optional: FAZYRV_RF_PORT_WMASK_EN adds wstrb_i byte write strobes.
module fazyrv_rf_port
    import fazyrv_rf_port_pkg::*;
#(
    parameter int CHUNKSIZE = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_in,
    input  logic                 gnt_i,
    input  logic                 req_i,
    input  logic                 wr_i,
    input  logic [4:0]           addr_i,
    input  logic [31:0]          wdat_i,
`ifdef FAZYRV_RF_PORT_WMASK_EN
    input  logic [3:0]           wstrb_i,
`endif
    output logic                 ready_o,
    output logic [31:0]          rdat_o,
    output logic                 rf_shft_o,
    output logic                 rf_shft_rd_o,
    output logic [4:0]           rf_rs1_o,
    output logic [4:0]           rf_rs2_o,
    output logic [4:0]           rf_rd_o,
    output logic [CHUNKSIZE-1:0] rf_res_o,
    output logic                 rf_we_o,
    input  logic [CHUNKSIZE-1:0] rf_ra_i
);

    localparam int NCHUNK = nchunk(CHUNKSIZE);
    localparam int CW     = cntw(CHUNKSIZE);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CW-1:0]        r_cnt;
    logic [CW-1:0]        w_cnt_nxt;
    logic [4:0]           r_addr;
    logic                 r_wr;
    logic                 w_accept;
    logic                 w_go;
    logic                 w_wen;
    logic [CHUNKSIZE-1:0] w_wsr_lsb;
    logic [CHUNKSIZE-1:0] w_cap_in;
    logic [31:0]          w_cap;

    assign w_accept = (r_state == IDLE) && req_i && gnt_i;
    assign w_go     = (r_state == SHIFT) && gnt_i;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_accept) w_state_nxt = SHIFT;
            end
            SHIFT: begin
                if (gnt_i) begin
                    if (r_cnt == CW'(NCHUNK - 1)) begin
                        w_state_nxt = DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr <= addr_i;
                r_wr   <= wr_i;
            end
        end
    end

`ifdef FAZYRV_RF_PORT_WMASK_EN
    logic [3:0] r_wstrb;

    always_ff @(posedge clk_i) begin
        if (!rst_in) begin
            r_wstrb <= '0;
        end else if (w_accept) begin
            r_wstrb <= wstrb_i;
        end
    end

    // Byte lane of the chunk currently under the RF head.
    assign w_wen = r_wr &
        r_wstrb[2'((32'(r_cnt) * CHUNKSIZE) >> 3)];
`else
    assign w_wen = r_wr;
`endif

    // x0 reads as zero regardless of what the RF presents.
    assign w_cap_in = (r_addr == 5'd0) ? '0 : rf_ra_i;

    fazyrv_rf_port_sreg #(
        .CHUNKSIZE(CHUNKSIZE)
    ) u_sreg (
        .clk_i  (clk_i),
        .rst_in (rst_in),
        .load_i (w_accept),
        .wdat_i (wdat_i),
        .shift_i(w_go),
        .in_i   (w_cap_in),
        .out_o  (w_wsr_lsb),
        .cap_o  (w_cap)
    );

    assign ready_o      = (r_state == DONE);
    assign rdat_o       = w_cap;
    assign rf_shft_o    = w_go;
    assign rf_shft_rd_o = 1'b0;
    assign rf_we_o      = w_go & w_wen;
    assign rf_res_o     = w_go ? w_wsr_lsb : '0;
    assign rf_rs1_o     = r_addr;
    assign rf_rs2_o     = r_addr;
    assign rf_rd_o      = r_addr;

endmodule

// File: tb/tb_fazyrv_rf_port.sv
// Directed bench for fazyrv_rf_port with a behavioural rotating RF model.
// Covers reset, write/read, x0, gnt pauses, reset mid-shift, ignored req.
module tb_fazyrv_rf_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        gnt = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [4:0]  addr = '0;
    logic [31:0] wdat = '0;
    logic [3:0]  wstrb = 4'hF;
    logic        ready;
    logic [31:0] rdat;
    logic        shft;
    logic        shft_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [1:0]  res;
    logic        we;
    logic [1:0]  ra;

    int n_vec = 0;
    int n_err = 0;

    int          n_shft;
    int          n_pause_act;
    logic [31:0] res_word;

    always #5 clk = ~clk;

    fazyrv_rf_port #(.CHUNKSIZE(2)) dut (
        .clk_i       (clk),
        .rst_in      (rst_n),
        .gnt_i       (gnt),
        .req_i       (req),
        .wr_i        (wr),
        .addr_i      (addr),
        .wdat_i      (wdat),
`ifdef FAZYRV_RF_PORT_WMASK_EN
        .wstrb_i     (wstrb),
`endif
        .ready_o     (ready),
        .rdat_o      (rdat),
        .rf_shft_o   (shft),
        .rf_shft_rd_o(shft_rd),
        .rf_rs1_o    (rs1),
        .rf_rs2_o    (rs2),
        .rf_rd_o     (rd),
        .rf_res_o    (res),
        .rf_we_o     (we),
        .rf_ra_i     (ra)
    );

    // Rotating RF model: x[rs2] presents its LSB chunk, shifts rotate x[rd].
    logic [31:0] regs [32];
    logic        init_done = 1'b0;

    assign ra = (rs2 == 5'd0) ? 2'b00 : regs[rs2][1:0];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'hC0DE0000 | 32'(i);
            regs[0] <= 32'h0;
            regs[3] <= 32'hAABBCCDD;
            init_done <= 1'b1;
        end else if (shft && rd != 5'd0) begin
            regs[rd] <= {we ? res : regs[rd][1:0], regs[rd][31:2]};
        end
    end

    task automatic run_op(
        input  logic        op_wr,
        input  logic [4:0]  op_addr,
        input  logic [31:0] op_dat,
        input  int          p_at,
        input  int          p_len,
        input  int          pulse_at,
        output logic [31:0] op_rd,
        output int          lat
    );
        n_shft = 0;
        n_pause_act = 0;
        res_word = '0;
        lat = 0;
        op_rd = '0;
        @(negedge clk);
        req = 1'b1;
        wr = op_wr;
        addr = op_addr;
        wdat = op_dat;
        gnt = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (c == pulse_at) begin
                req = 1'b1;
                wr = 1'b1;
                addr = 5'd9;
                wdat = 32'hFFFFFFFF;
            end
            gnt = !(p_len > 0 && c > p_at && c <= p_at + p_len);
            #1;
            if (shft) begin
                n_shft++;
                res_word = {res, res_word[31:2]};
            end
            if (!gnt && (shft || we)) n_pause_act++;
            if (ready) begin
                lat = c;
                op_rd = rdat;
                break;
            end
        end
        req = 1'b0;
        gnt = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready got %b want 0", ready);
        end
        n_vec++;
        if (rdat !== 32'h0) begin
            n_err++;
            $display("FAIL reset_rdat got %h want 0", rdat);
        end
        n_vec++;
        if ({shft, we, shft_rd} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl got %b want 000", {shft, we, shft_rd});
        end
        n_vec++;
        if (res !== 2'b00) begin
            n_err++;
            $display("FAIL reset_res got %b want 00", res);
        end
        n_vec++;
        if ({rs1, rs2, rd} !== 15'h0) begin
            n_err++;
            $display("FAIL reset_addr got %h want 0", {rs1, rs2, rd});
        end
    endtask

    task automatic test_write_read();
        logic [31:0] v;
        int          l;
        run_op(1'b1, 5'd5, 32'hDEADBEEF, 0, 0, 0, v, l);
        n_vec++;
        if (n_shft !== 16) begin
            n_err++;
            $display("FAIL wr5_shifts got %0d want 16", n_shft);
        end
        n_vec++;
        if (res_word !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL wr5_res_seq got %h want deadbeef", res_word);
        end
        n_vec++;
        if (l !== 17) begin
            n_err++;
            $display("FAIL wr5_latency got %0d want 17", l);
        end
        n_vec++;
        if (v !== 32'hC0DE0005) begin
            n_err++;
            $display("FAIL wr5_old got %h want c0de0005", v);
        end
        run_op(1'b0, 5'd5, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd5 got %h want deadbeef", v);
        end
        n_vec++;
        if (l !== 17) begin
            n_err++;
            $display("FAIL rd5_latency got %0d want 17", l);
        end
    endtask

    task automatic test_x0();
        logic [31:0] v;
        int          l;
        run_op(1'b0, 5'd0, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'h0 || l !== 17) begin
            n_err++;
            $display("FAIL rd0 got %h/%0d want 0/17", v, l);
        end
        run_op(1'b1, 5'd0, 32'hFFFFFFFF, 0, 0, 0, v, l);
        n_vec++;
        if (n_shft !== 16) begin
            n_err++;
            $display("FAIL wr0_shifts got %0d want 16", n_shft);
        end
        run_op(1'b0, 5'd0, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL rd0_after_wr got %h want 0", v);
        end
    endtask

    task automatic test_pause();
        logic [31:0] v;
        int          l;
        run_op(1'b1, 5'd7, 32'h12345678, 4, 5, 0, v, l);
        n_vec++;
        if (l !== 22) begin
            n_err++;
            $display("FAIL pause_latency got %0d want 22", l);
        end
        n_vec++;
        if (n_pause_act !== 0) begin
            n_err++;
            $display("FAIL pause_active got %0d want 0", n_pause_act);
        end
        n_vec++;
        if (n_shft !== 16) begin
            n_err++;
            $display("FAIL pause_shifts got %0d want 16", n_shft);
        end
        run_op(1'b0, 5'd7, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'h12345678) begin
            n_err++;
            $display("FAIL rd7 got %h want 12345678", v);
        end
        run_op(1'b0, 5'd6, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'hC0DE0006) begin
            n_err++;
            $display("FAIL rd6 got %h want c0de0006", v);
        end
        run_op(1'b0, 5'd8, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'hC0DE0008) begin
            n_err++;
            $display("FAIL rd8 got %h want c0de0008", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        int          l;
        int          act;
        @(negedge clk);
        req = 1'b1;
        wr = 1'b1;
        addr = 5'd10;
        wdat = 32'h0F0F0F0F;
        @(negedge clk);
        req = 1'b0;
        repeat (6) @(negedge clk);
        // cycle 8 of SHIFT
        rst_n = 1'b0;
        req = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if (ready !== 1'b0 || rdat !== 32'h0) begin
            n_err++;
            $display("FAIL rstmid_out got %b/%h want 0/0", ready, rdat);
        end
        n_vec++;
        if (shft !== 1'b0 || we !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_ctl got %b%b want 00", shft, we);
        end
        rst_n = 1'b1;
        req = 1'b0;
        act = 0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (shft || ready) act++;
        end
        n_vec++;
        if (act !== 0) begin
            n_err++;
            $display("FAIL rstmid_idle got %0d active want 0", act);
        end
        run_op(1'b0, 5'd6, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'hC0DE0006 || l !== 17) begin
            n_err++;
            $display("FAIL rstmid_rd6 got %h/%0d want c0de0006/17", v, l);
        end
    endtask

    task automatic test_ignore_req();
        logic [31:0] v;
        int          l;
        run_op(1'b1, 5'd11, 32'h0BADF00D, 0, 0, 5, v, l);
        n_vec++;
        if (l !== 17 || v !== 32'hC0DE000B) begin
            n_err++;
            $display("FAIL ign_wr11 got %h/%0d want c0de000b/17", v, l);
        end
        run_op(1'b0, 5'd9, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'hC0DE0009) begin
            n_err++;
            $display("FAIL ign_rd9 got %h want c0de0009", v);
        end
        run_op(1'b0, 5'd11, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'h0BADF00D) begin
            n_err++;
            $display("FAIL ign_rd11 got %h want 0badf00d", v);
        end
    endtask

`ifdef FAZYRV_RF_PORT_WMASK_EN
    task automatic test_wmask();
        logic [31:0] v;
        int          l;
        wstrb = 4'b0101;
        run_op(1'b1, 5'd3, 32'h11223344, 0, 0, 0, v, l);
        wstrb = 4'hF;
        n_vec++;
        if (v !== 32'hAABBCCDD) begin
            n_err++;
            $display("FAIL wm_old got %h want aabbccdd", v);
        end
        run_op(1'b0, 5'd3, 32'h0, 0, 0, 0, v, l);
        n_vec++;
        if (v !== 32'hAA22CC44) begin
            n_err++;
            $display("FAIL wm_rd3 got %h want aa22cc44", v);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_x0();
        test_pause();
        test_reset_mid();
        test_ignore_req();
`ifdef FAZYRV_RF_PORT_WMASK_EN
        test_wmask();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fazyrv_rf_port.md
Name: fazyrv_rf_port

Overview:
Word-level access port and initiator for the chunk-serial register-file interface (shft/we/rd/res out, ra in).
- Converts one 32-bit read or write of register x[addr] into a full rotation of 32/CHUNKSIZE shift cycles on that interface.
- Used by debug/boot logic to load or inspect architectural registers while the core is parked.
- Sits beside the core's own RF driver, muxed in when gnt_i is high.

Parameters:
CHUNKSIZE, 2, data path width of the core; legal 1, 2, 4, 8; NCHUNK = 32/CHUNKSIZE.

Ports:
clk_i  in  1  clock, rising edge
rst_in  in  1  reset, synchronous, active-low
gnt_i  in  1  RF interface granted to this block; low pauses shifting
req_i  in  1  request strobe, sampled in IDLE
wr_i  in  1  1 = write, 0 = read; sampled with req_i
addr_i  in  5  register index
wdat_i  in  32  write data; sampled with req_i
ready_o  out  1  one-cycle completion pulse
rdat_o  out  32  old register contents; valid while ready_o is high
rf_shft_o  out  1  to RF shft_i
rf_shft_rd_o  out  1  to RF shft_rd_i; tied 0
rf_rs1_o  out  5  to RF rs1_i
rf_rs2_o  out  5  to RF rs2_i; equals addr
rf_rd_o  out  5  to RF rd_i
rf_res_o  out  CHUNKSIZE  to RF res_i
rf_we_o  out  1  to RF we_i
rf_ra_i  in  CHUNKSIZE  from RF ra_o

Behaviour:
- Chunk order: RF presents chunk k (bits k*CHUNKSIZE+:CHUNKSIZE) LSB-first. An unwritten register rotates, so NCHUNK shifts restore alignment.
- Reset values: state IDLE, cnt 0, ready_o 0, rdat_o 0, rf_shft_o 0, rf_we_o 0, rf_res_o 0, latched addr 0.
- IDLE:
  - If req_i && gnt_i: latch addr, wr and wdat into a 32-bit shift register; clear capture register; go to SHIFT.
  - If req_i && !gnt_i: ignored; the requester holds req_i until accepted.
- SHIFT, gnt_i high:
  - Drive rf_shft_o=1 and rf_we_o=wr (per-chunk masking below).
  - Drive rf_res_o = wsr[CHUNKSIZE-1:0] and shift wsr right by CHUNKSIZE.
  - Capture cap <= {rf_ra_i, cap[31:CHUNKSIZE]}; cnt++.
  - When cnt==NCHUNK-1, go to DONE.
- SHIFT, gnt_i low: rf_shft_o=0, rf_we_o=0; cnt, wsr and cap hold. Paused cycles only add latency.
- DONE: ready_o=1 and rdat_o=cap for exactly one cycle, then IDLE. rdat_o holds its value afterwards until the next capture.
- Latency: NCHUNK shift cycles + 1 DONE cycle after acceptance, with no pauses (CHUNKSIZE=2: 17 cycles).
- Combinational outputs: rf_rs1_o=rf_rs2_o=rf_rd_o=latched addr; rf_shft_o and rf_we_o are valid only in SHIFT with gnt_i.
- addr 0: the full sequence still runs. The write has no effect and rdat_o=0.
- req_i outside IDLE is ignored; there is no queueing.
- Reset mid-SHIFT: return to IDLE immediately and drop outputs low. RF alignment becomes undefined, consistent with the RF having no reset; system reset reinitialises.
- cnt width: $clog2(NCHUNK) bits, minimum 1.

Optional Feature:
FAZYRV_RF_PORT_WMASK_EN
- With the macro: adds input wstrb_i[3:0], sampled with req_i.
  - In a write, chunk k asserts rf_we_o only if wstrb_i[(k*CHUNKSIZE)/8].
  - Masked-off chunks rotate unchanged.
  - rdat_o still returns the full old value.
- Without the macro: no wstrb_i port; writes are full-word.

Decomposition:
- Package fazyrv_rf_port_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - localparam function nchunk(CHUNKSIZE)
- Sub-module fazyrv_rf_port_sreg: 32-bit chunk shifter with load, shift-out LSB chunk, shift-in MSB chunk. One instance each for wsr and cap, or one combined instance.
- FSM and counter stay in the top module.

Test Plan:
1. Write x5=0xDEADBEEF, gnt_i=1 constant, CHUNKSIZE=2:
   - rf_shft_o high exactly 16 cycles; rf_res_o sequence 3,3,2,3,...; ready_o at cycle 17.
   - Then read x5 → rdat_o=0xDEADBEEF.
2. Read x0 → rdat_o=0x00000000 after 17 cycles. Write x0=0xFFFFFFFF, then read → still 0.
3. Write x7=0x12345678, gnt_i low for 5 cycles after 4 shifts:
   - rf_shft_o low during the pause; ready_o at cycle 22.
   - Read-back = 0x12345678; x6 and x8 unchanged.
4. Reset asserted during cycle 8 of SHIFT:
   - Next cycle IDLE, ready_o=0, rdat_o=0, rf_shft_o=0.
   - req_i during reset is ignored.
5. req_i pulsed again in SHIFT with wr_i=1 and addr 9 → ignored; x9 unchanged.
6. (WMASK_EN) x3=0xAABBCCDD, write 0x11223344 with wstrb_i=4'b0101 → read 0xAA22CC44; rdat_o of the write = 0xAABBCCDD.
